// File: rtl/gottagofast_pkg.sv
// Shared types, default timing constants and bank decode for the FastRAM DRAM sequencer.
package gottagofast_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    HOLD,
    PRECHARGE,
    REF_CAS,
    REF_RAS,
    REF_END
  } state_t;

  // 108 cycles of the 7.09MHz bus clock is roughly 15.2us between CBR refreshes.
  localparam int REFRESH_INTERVAL_DEFAULT = 108;
  localparam int MAX_PENDING_DEFAULT      = 4;
  localparam int ROW_BITS_DEFAULT         = 10;

  // Active-low RAS pattern for a bank: bank 00 drives RAS4n, 01..11 drive RAS1n..RAS3n.
  function automatic logic [3:0] bank_rasn(input logic [1:0] bank);
    logic [3:0] rasn;
    case (bank)
      2'b00:   rasn = 4'b0111;
      2'b01:   rasn = 4'b1110;
      2'b10:   rasn = 4'b1101;
      default: rasn = 4'b1011;
    endcase
    return rasn;
  endfunction

endpackage

// File: rtl/dram_sequencer_refresh_timer.sv
// Refresh interval timer plus saturating count of refreshes that are owed but not yet run.
module refresh_timer
  import gottagofast_pkg::*;
#(
  parameter int INTERVAL    = REFRESH_INTERVAL_DEFAULT,
  parameter int MAX_PENDING = MAX_PENDING_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic dec,
  output logic pending_nonzero,
  output logic pending_full
);

  localparam int TW = $clog2(INTERVAL);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [TW-1:0] RELOAD = TW'(INTERVAL - 1);
  localparam logic [PW-1:0] FULL   = PW'(MAX_PENDING);

  logic [TW-1:0] count;
  logic [PW-1:0] pending;
  logic          tick;

  assign tick            = (count == '0);
  assign pending_nonzero = (pending != '0);
  assign pending_full    = (pending == FULL);

  // Free-running down-counter; the cycle it sits at zero is the tick, and it reloads on that edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= RELOAD;
    end else if (tick) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

  // A tick owes one more refresh, starting one pays one off; both together cancel out.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending <= '0;
    end else if (tick && !dec) begin
      if (pending != FULL) begin
        pending <= pending + 1'b1;
      end
    end else if (dec && !tick) begin
      if (pending != '0) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_sequencer.sv
// DRAM timing sequencer for the Zorro II FastRAM card: RAS/CAS/MADDR/MEMWn generation and CBR refresh.
module dram_sequencer
  import gottagofast_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
  parameter int MAX_PENDING      = MAX_PENDING_DEFAULT,
  parameter int ROW_BITS         = ROW_BITS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  req,
  input  logic                  rw,
  input  logic                  uds_n,
  input  logic                  lds_n,
  input  logic [1:0]            bank_sel,
  input  logic [2*ROW_BITS-1:0] addr,
  output logic [3:0]            RASn,
  output logic                  UCASn,
  output logic                  LCASn,
  output logic [ROW_BITS-1:0]   MADDR,
  output logic                  MEMWn,
  output logic                  ack,
  output logic                  refresh_busy
);

  state_t state;
  state_t next_state;

  logic [3:0] rasn_d;
  logic       ucasn_d;
  logic       lcasn_d;
  logic       memwn_d;
  logic       ack_d;
  logic       busy_d;

  logic ref_dec;
  logic pending_nonzero;
  logic pending_full;

  // The pending count drops as the sequencer commits to the RAS half of a refresh.
  assign ref_dec = (state == REF_CAS);

  refresh_timer #(
    .INTERVAL    (REFRESH_INTERVAL),
    .MAX_PENDING (MAX_PENDING)
  ) u_refresh_timer (
    .clk             (CLK),
    .resetn          (RESETn),
    .dec             (ref_dec),
    .pending_nonzero (pending_nonzero),
    .pending_full    (pending_full)
  );

  // Next state, then the strobe levels that state will present; they are registered so pins never see a comb path.
  always_comb begin
    next_state = state;
    rasn_d     = 4'hF;
    ucasn_d    = 1'b1;
    lcasn_d    = 1'b1;
    memwn_d    = 1'b1;
    ack_d      = 1'b0;
    busy_d     = 1'b0;

    case (state)
      IDLE: begin
        if (pending_full) begin
          next_state = REF_CAS;
        end else if (req) begin
          next_state = ROW;
        end else if (pending_nonzero) begin
          next_state = REF_CAS;
        end
      end
      ROW:       next_state = req ? COL : PRECHARGE;
      COL:       next_state = HOLD;
      HOLD:      next_state = req ? HOLD : PRECHARGE;
      PRECHARGE: next_state = IDLE;
      REF_CAS:   next_state = REF_RAS;
      REF_RAS:   next_state = REF_END;
      REF_END:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase

    case (next_state)
      ROW: begin
        rasn_d  = bank_rasn(bank_sel);
        memwn_d = rw;
      end
      COL, HOLD: begin
        rasn_d  = RASn;
        ucasn_d = uds_n;
        lcasn_d = lds_n;
        memwn_d = rw;
        ack_d   = 1'b1;
      end
      REF_CAS: begin
        ucasn_d = 1'b0;
        lcasn_d = 1'b0;
        busy_d  = 1'b1;
      end
      REF_RAS: begin
        rasn_d  = 4'h0;
        ucasn_d = 1'b0;
        lcasn_d = 1'b0;
        busy_d  = 1'b1;
      end
      REF_END: begin
        busy_d  = 1'b1;
      end
      default: begin
        rasn_d  = 4'hF;
      end
    endcase
  end

  // State and strobe registers; reset drops every strobe at once with no precharge cycle.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state        <= IDLE;
      RASn         <= 4'hF;
      UCASn        <= 1'b1;
      LCASn        <= 1'b1;
      MEMWn        <= 1'b1;
      ack          <= 1'b0;
      refresh_busy <= 1'b0;
    end else begin
      state        <= next_state;
      RASn         <= rasn_d;
      UCASn        <= ucasn_d;
      LCASn        <= lcasn_d;
      MEMWn        <= memwn_d;
      ack          <= ack_d;
      refresh_busy <= busy_d;
    end
  end

  // Row address follows the bus while idle; the column is captured as RAS falls so it is settled for CAS.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      MADDR <= '0;
    end else if (state == IDLE) begin
      if (next_state == ROW) begin
        MADDR <= addr[ROW_BITS-1:0];
      end else begin
        MADDR <= addr[2*ROW_BITS-1:ROW_BITS];
      end
    end
  end

endmodule

// File: tb/tb_dram_sequencer.sv
// Self-checking bench for dram_sequencer: per-cycle vector table plus refresh timing and saturation sequences.
module tb_dram_sequencer;

  logic        CLK;
  logic        RESETn;
  logic        req;
  logic        rw;
  logic        uds_n;
  logic        lds_n;
  logic [1:0]  bank_sel;
  logic [19:0] addr;
  logic [3:0]  RASn;
  logic        UCASn;
  logic        LCASn;
  logic [9:0]  MADDR;
  logic        MEMWn;
  logic        ack;
  logic        refresh_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [19:0] ADDR_A = 20'hABCDE;
  localparam logic [19:0] ADDR_B = 20'h12345;

  typedef struct packed {
    logic        resetn;
    logic        req;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [1:0]  bank_sel;
    logic [19:0] addr;
    logic [3:0]  rasn;
    logic        ucasn;
    logic        lcasn;
    logic [9:0]  maddr;
    logic        memwn;
    logic        ack;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  dram_sequencer dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .req          (req),
    .rw           (rw),
    .uds_n        (uds_n),
    .lds_n        (lds_n),
    .bank_sel     (bank_sel),
    .addr         (addr),
    .RASn         (RASn),
    .UCASn        (UCASn),
    .LCASn        (LCASn),
    .MADDR        (MADDR),
    .MEMWn        (MEMWn),
    .ack          (ack),
    .refresh_busy (refresh_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input logic rn, input logic rq, input logic w, input logic u, input logic l,
                         input logic [1:0] b, input logic [19:0] a,
                         input logic [3:0] e_rasn, input logic e_uc, input logic e_lc,
                         input logic [9:0] e_ma, input logic e_mw, input logic e_ack, input logic e_busy);
    vec_t v;
    v.resetn   = rn;
    v.req      = rq;
    v.rw       = w;
    v.uds_n    = u;
    v.lds_n    = l;
    v.bank_sel = b;
    v.addr     = a;
    v.rasn     = e_rasn;
    v.ucasn    = e_uc;
    v.lcasn    = e_lc;
    v.maddr    = e_ma;
    v.memwn    = e_mw;
    v.ack      = e_ack;
    v.busy     = e_busy;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    RESETn   = v.resetn;
    req      = v.req;
    rw       = v.rw;
    uds_n    = v.uds_n;
    lds_n    = v.lds_n;
    bank_sel = v.bank_sel;
    addr     = v.addr;
  endtask

  task automatic do_reset();
    RESETn   = 1'b0;
    req      = 1'b0;
    rw       = 1'b1;
    uds_n    = 1'b1;
    lds_n    = 1'b1;
    bank_sel = 2'b00;
    addr     = 20'h0;
    step();
    step();
    RESETn   = 1'b1;
  endtask

  initial begin
    int first;
    int edge_no;
    int bad;
    int ras_all_low;

    RESETn   = 1'b0;
    req      = 1'b0;
    rw       = 1'b1;
    uds_n    = 1'b1;
    lds_n    = 1'b1;
    bank_sel = 2'b00;
    addr     = 20'h0;

    // Reset, read on bank 01, write on bank 00 with a late UDS change, back-to-back byte-disabled
    // cycle, ROW abort, then reset in the middle of COL.
    add_vec(1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,20'h0,   4'hF,1'b1,1'b1,10'h000,1'b1,1'b0,1'b0);
    add_vec(1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,20'h0,   4'hF,1'b1,1'b1,10'h000,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,ADDR_A,  4'hF,1'b1,1'b1,10'h2AF,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b0,1'b1,2'b01,ADDR_A,  4'hE,1'b1,1'b1,10'h0DE,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b0,1'b1,2'b01,ADDR_A,  4'hE,1'b0,1'b1,10'h0DE,1'b1,1'b1,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b0,1'b1,2'b01,ADDR_A,  4'hE,1'b0,1'b1,10'h0DE,1'b1,1'b1,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b0,1'b1,2'b01,ADDR_A,  4'hE,1'b0,1'b1,10'h0DE,1'b1,1'b1,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b0,1'b1,2'b01,ADDR_A,  4'hE,1'b0,1'b1,10'h0DE,1'b1,1'b1,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b0,1'b1,2'b01,ADDR_A,  4'hF,1'b1,1'b1,10'h0DE,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,ADDR_B,  4'hF,1'b1,1'b1,10'h0DE,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,ADDR_B,  4'hF,1'b1,1'b1,10'h048,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,ADDR_B,  4'h7,1'b1,1'b1,10'h345,1'b0,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,ADDR_B,  4'h7,1'b0,1'b0,10'h345,1'b0,1'b1,1'b0);
    add_vec(1'b1,1'b1,1'b0,1'b1,1'b0,2'b00,ADDR_B,  4'h7,1'b1,1'b0,10'h345,1'b0,1'b1,1'b0);
    add_vec(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,ADDR_B,  4'hF,1'b1,1'b1,10'h345,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b1,1'b1,2'b10,ADDR_B,  4'hF,1'b1,1'b1,10'h345,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b1,1'b1,2'b10,ADDR_B,  4'hD,1'b1,1'b1,10'h345,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b1,1'b1,2'b10,ADDR_B,  4'hD,1'b1,1'b1,10'h345,1'b1,1'b1,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b10,ADDR_B,  4'hD,1'b1,1'b1,10'h345,1'b1,1'b1,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b10,ADDR_B,  4'hF,1'b1,1'b1,10'h345,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,ADDR_A,  4'hF,1'b1,1'b1,10'h345,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,ADDR_A,  4'hF,1'b1,1'b1,10'h2AF,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b1,1'b0,1'b0,2'b11,ADDR_A,  4'hB,1'b1,1'b1,10'h0DE,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b0,1'b0,2'b11,ADDR_A,  4'hF,1'b1,1'b1,10'h0DE,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b0,1'b0,2'b11,ADDR_A,  4'hF,1'b1,1'b1,10'h0DE,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,ADDR_A,  4'hE,1'b1,1'b1,10'h0DE,1'b0,1'b0,1'b0);
    add_vec(1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,ADDR_A,  4'hE,1'b0,1'b0,10'h0DE,1'b0,1'b1,1'b0);
    add_vec(1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,ADDR_A,  4'hF,1'b1,1'b1,10'h000,1'b1,1'b0,1'b0);
    add_vec(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,ADDR_A,  4'hF,1'b1,1'b1,10'h2AF,1'b1,1'b0,1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i),
                  32'({RASn, UCASn, LCASn, MADDR, MEMWn, ack, refresh_busy}),
                  32'({vecs[i].rasn, vecs[i].ucasn, vecs[i].lcasn, vecs[i].maddr,
                       vecs[i].memwn, vecs[i].ack, vecs[i].busy}));
    end

    // Idle after reset: the first refresh starts on edge 109, CAS before RAS, then every 108 edges.
    do_reset();
    first = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (refresh_busy) begin
        first = k;
        break;
      end
    end
    checkOutput("first_refresh_edge", 32'(first), 32'(109));
    checkOutput("ref_cas", 32'({RASn, UCASn, LCASn, MEMWn}), 32'({4'hF, 1'b0, 1'b0, 1'b1}));
    step();
    checkOutput("ref_ras", 32'({RASn, UCASn, LCASn, MEMWn, refresh_busy}), 32'({4'h0, 1'b0, 1'b0, 1'b1, 1'b1}));
    step();
    checkOutput("ref_end", 32'({RASn, UCASn, LCASn, MEMWn, refresh_busy}), 32'({4'hF, 1'b1, 1'b1, 1'b1, 1'b1}));
    step();
    checkOutput("ref_back_idle", 32'({RASn, UCASn, LCASn, MEMWn, refresh_busy}), 32'({4'hF, 1'b1, 1'b1, 1'b1, 1'b0}));
    edge_no = 112;
    first = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      edge_no++;
      if (refresh_busy) begin
        first = edge_no;
        break;
      end
    end
    checkOutput("second_refresh_edge", 32'(first), 32'(217));

    // One long access spans five ticks, so the owed count saturates and pre-empts the next request.
    do_reset();
    req      = 1'b1;
    rw       = 1'b1;
    bank_sel = 2'b01;
    uds_n    = 1'b0;
    lds_n    = 1'b0;
    addr     = ADDR_A;
    step();
    checkOutput("sat_row_rasn", 32'(RASn), 32'(4'hE));
    step();
    checkOutput("sat_col_ack", 32'(ack), 32'(1'b1));
    bad = 0;
    for (int e = 3; e <= 550; e++) begin
      step();
      if (ack !== 1'b1 || refresh_busy !== 1'b0) bad++;
    end
    checkOutput("sat_hold_unbroken", 32'(bad), 32'(0));
    req = 1'b0;
    step();
    checkOutput("sat_precharge", 32'({RASn, UCASn, LCASn, MEMWn, ack}), 32'({4'hF, 1'b1, 1'b1, 1'b1, 1'b0}));
    req      = 1'b1;
    bank_sel = 2'b10;
    uds_n    = 1'b0;
    lds_n    = 1'b1;
    step();
    checkOutput("sat_idle", 32'({RASn, refresh_busy}), 32'({4'hF, 1'b0}));
    step();
    checkOutput("sat_preempt", 32'({RASn, UCASn, LCASn, refresh_busy, ack}), 32'({4'hF, 1'b0, 1'b0, 1'b1, 1'b0}));
    step();
    checkOutput("sat_preempt_ras", 32'(RASn), 32'(4'h0));
    edge_no = 554;
    first = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      edge_no++;
      if (ack) begin
        first = edge_no;
        break;
      end
    end
    checkOutput("sat_ack_edge", 32'(first), 32'(558));
    checkOutput("sat_ack_strobes", 32'({RASn, UCASn, LCASn}), 32'({4'hD, 1'b0, 1'b1}));
    req = 1'b0;
    ras_all_low = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (RASn == 4'h0) ras_all_low++;
    end
    checkOutput("sat_owed_refreshes", 32'(ras_all_low), 32'(3));
    checkOutput("sat_final_idle", 32'({RASn, refresh_busy, ack}), 32'({4'hF, 1'b0, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dram_sequencer.md
Name: dram_sequencer

Overview:
- Synchronous DRAM timing sequencer for the 8MB Zorro II FastRAM card.
- Sits directly downstream of the bus-side decode/autoconfig stage. That stage supplies a qualified access request (address matched, ASn low), bank select, strobes and address.
- Drives the four RAS banks, UCAS/LCAS, the muxed MADDR and MEMWn. Returns an ack that the decode stage uses to release DTACKn.
- Replaces refresh-on-every-idle-cycle with a timed CBR refresh scheduler. Deferred refreshes are counted, and refresh is forced once the deferral limit is reached.

Parameters:
- REFRESH_INTERVAL, 108, CLK cycles between refresh ticks (about 15.2us at 7.09MHz).
- MAX_PENDING, 4, saturation limit of the deferred-refresh counter. At this limit refresh pre-empts access.
- ROW_BITS, 10, width of MADDR (row and column).

Ports:
- CLK  in  1  7MHz bus clock; all logic on posedge.
- RESETn  in  1  active-low reset, synchronous to CLK.
- req  in  1  access request from decode stage; held high for the whole bus cycle.
- rw  in  1  1 = read, 0 = write; valid while req is high.
- uds_n  in  1  upper data strobe.
- lds_n  in  1  lower data strobe.
- bank_sel  in  2  RAS bank select (00→RAS4n, 01→RAS1n, 10→RAS2n, 11→RAS3n).
- addr  in  20  ADDR[20:1]. Row is addr[20:11], column is addr[10:1].
- RASn  out  4  RAS per bank; bit0 = RAS1n … bit3 = RAS4n.
- UCASn  out  1  upper CAS.
- LCASn  out  1  lower CAS.
- MADDR  out  ROW_BITS  muxed DRAM address.
- MEMWn  out  1  DRAM write enable, active low.
- ack  out  1  data phase active; decode stage may assert DTACKn.
- refresh_busy  out  1  high while in any REF_* state.

Behaviour:
- Interface: one clock, CLK. RESETn is synchronous and active-low.
- Outputs are registered; no combinational path from inputs to DRAM strobes.
- Reset: state=IDLE; RASn=4'hF; UCASn=LCASn=1; MEMWn=1; ack=0; refresh_busy=0; MADDR=0; refresh timer=REFRESH_INTERVAL-1; pending=0.
- Reset asserted mid-cycle takes effect at the next edge. All strobes go inactive immediately, with no precharge state.
- Refresh timer:
  - Down-counter, decremented every cycle.
  - On reaching 0 it reloads REFRESH_INTERVAL-1 and pulses tick.
  - tick increments pending, saturating at MAX_PENDING.
  - Entering REF_RAS decrements pending.
  - tick coinciding with that decrement leaves pending unchanged.
- MADDR:
  - Loads addr[20:11] every cycle in IDLE.
  - Loads addr[10:1] on the IDLE→ROW edge, so the column is stable for COL.
  - Holds otherwise.
- State machine:
  - IDLE:
    - pending==MAX_PENDING → REF_CAS, even if req is high.
    - Otherwise req → ROW.
    - Otherwise pending>0 → REF_CAS.
    - Otherwise stay in IDLE.
  - ROW: selected RASn bit low. MEMWn=rw. If req drops, go to PRECHARGE with no ack; otherwise → COL.
  - COL: RAS held. UCASn=uds_n, LCASn=lds_n. ack=1. → HOLD.
  - HOLD: strobes and ack held while req=1. On req=0 → PRECHARGE.
  - PRECHARGE: all RAS/CAS high, MEMWn=1, ack=0. Lasts exactly 1 cycle, then → IDLE.
  - REF_CAS: UCASn=LCASn=0, MEMWn=1, RASn=F. refresh_busy=1. → REF_RAS.
  - REF_RAS: RASn=4'h0, CAS held low. Decrement pending. → REF_END.
  - REF_END: all RAS/CAS high. → IDLE.
- Latency: req seen in IDLE → RAS low 1 edge later → CAS low and ack 2 edges later.
- A req arriving during a refresh is serviced after REF_END+IDLE. Worst-case delay is 4 cycles.
- Back-to-back requests: a new req cannot start until 1 cycle after PRECHARGE (tRP ≥ 141ns).
- uds_n/lds_n both high in COL: no CAS and ack still 1 (byte-disabled cycle completes).
- Strobe inputs changing during HOLD are tracked, so a late write UDS/LDS is honoured.
- Never more than one RASn bit low during access. All four are low only in REF_RAS.

Decomposition:
- Shared package gottagofast_pkg holds:
  - the state enum {IDLE, ROW, COL, HOLD, PRECHARGE, REF_CAS, REF_RAS, REF_END};
  - the REFRESH_INTERVAL and MAX_PENDING defaults;
  - the bank_sel→RASn mapping function.
- One sub-module, refresh_timer:
  - inputs: interval counter, saturating pending counter, dec input;
  - outputs: pending_nonzero and pending_full.

Test Plan:
- Reset, then hold RESETn=1 with req=0 for 108 cycles → the first REF_CAS occurs exactly 1 cycle after the first tick. Each refresh is CAS 1 cycle before RAS, all 4 RASn low for 1 cycle, MEMWn=1 throughout.
- Read: bank_sel=01, addr=20'hABCDE, uds_n=0, lds_n=1, req held 5 cycles →
  - MADDR=10'h2AF (row) while RASn=4'b1110 falls;
  - MADDR=10'h0DE in COL, UCASn low, LCASn high, ack on the 2nd edge;
  - 1 precharge cycle after req falls.
- Write with both strobes: rw=0, bank_sel=00 → RASn=4'b0111, MEMWn low from ROW, both CAS low, MEMWn high in PRECHARGE.
- Keep req asserted continuously over 5×108 cycles → pending saturates at 4 and REF_CAS pre-empts the next request. Then ack is delayed ≤4 cycles and pending returns to 3.
- req drops while in ROW → no ack and no CAS. PRECHARGE is entered, then IDLE.
- RESETn low during COL → the next edge shows RASn=F, CAS high, ack=0, pending=0, and the timer reloads.
